// File: rtl/rf_pkg.sv
// Purpose: shared types and helpers for the register-file writeback path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rf_pkg;

    localparam int RF_AW = 4;
    localparam int RF_DW = 32;
    localparam logic [RF_AW-1:0] PC_REG = 4'd15;

    // One queued register-file write.
    typedef struct packed {
        logic [RF_AW-1:0] rd;
        logic [RF_DW-1:0] data;
    } wb_entry_t;

    // Register number to its bit in the 16-entry pending bitmap.
    function automatic logic [15:0] onehot16(input logic [RF_AW-1:0] rd);
        return 16'h0001 << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Purpose: in-order circular buffer, up to two pushes and one pop per clock.
// Latency: a pushed entry is visible at head_dat on the clock after the push.
// Backpressure: none internally; the caller must only push into free slots.
// Ports: clk/rst; push0_* (older) lands at tail, push1_* after it;
//        pop advances head; head_dat, entry_rd/entry_vld, count describe contents.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push0_vld,
    input  wb_entry_t                push0_dat,
    input  logic                     push1_vld,
    input  wb_entry_t                push1_dat,
    input  logic                     pop,
    output wb_entry_t                head_dat,
    output logic [RF_AW-1:0]         entry_rd [DEPTH],
    output logic [DEPTH-1:0]         entry_vld,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem_q [DEPTH];
    wb_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   slot1;
    logic [PTR_W-1:0]   offs [DEPTH];

    always_comb begin
        mem_d = mem_q;
        // push1 packs directly behind push0, or takes the tail slot itself
        // when push0 is idle, so the queue never holds holes.
        slot1 = push0_vld ? tail_q + PTR_W'(1) : tail_q;
        if (push0_vld) mem_d[tail_q] = push0_dat;
        if (push1_vld) mem_d[slot1]  = push1_dat;
        // Pointers are naturally modulo DEPTH since DEPTH is a power of two.
        tail_d  = tail_q + PTR_W'(push0_vld) + PTR_W'(push1_vld);
        head_d  = pop ? head_q + PTR_W'(1) : head_q;
        count_d = count_q + CNT_W'(push0_vld) + CNT_W'(push1_vld) - CNT_W'(pop);
    end

    // Slot i is live when its distance from head is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            offs[i]      = PTR_W'(i) - head_q;
            entry_vld[i] = {1'b0, offs[i]} < count_q;
            entry_rd[i]  = mem_q[i].rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing outside the head..tail window is read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_dat = mem_q[head_q];
    assign count    = count_q;

endmodule

// File: rtl/rf_writeback_queue.sv
// Purpose: merges MEM and ALU results into one in-order register-file write stream.
// Latency: result accepted at edge N into an empty queue is written at edge N+1.
// Backpressure: readies from registered occupancy only; ALU needs two free slots when MEM also offers.
// Ports: mem_*/alu_* valid-ready result inputs; C/PW/RFLd/PCLd register-file write port;
//        pending bitmap of queued destinations; count occupancy.
module rf_writeback_queue
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = RF_DW,   // must equal RF_DW (entry layout is fixed)
    parameter int AW    = RF_AW    // must equal RF_AW
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_rd,
    input  logic [DW-1:0]            mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_ready,
    output logic [AW-1:0]            C,
    output logic [DW-1:0]            PW,
    output logic                     RFLd,
    output logic                     PCLd,
    output logic [15:0]              pending,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t          push0_dat, push1_dat, head_dat;
    logic               push0_vld, push1_vld;
    logic [RF_AW-1:0]   entry_rd [DEPTH];
    logic [DEPTH-1:0]   entry_vld;
    logic [CNT_W-1:0]   count_w;
    logic [CNT_W-1:0]   free;

    // A same-cycle pop does not free a slot for acceptance; this keeps the
    // readies off the drain path entirely.
    always_comb begin
        free      = CNT_W'(DEPTH) - count_w;
        mem_ready = free >= CNT_W'(1);
        // MEM is older and always gets the first free slot.
        alu_ready = mem_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1));
    end

    assign push0_vld = mem_valid && mem_ready;
    assign push1_vld = alu_valid && alu_ready;
    assign push0_dat = '{rd: mem_rd, data: mem_data};
    assign push1_dat = '{rd: alu_rd, data: alu_data};

    wb_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push0_vld (push0_vld),
        .push0_dat (push0_dat),
        .push1_vld (push1_vld),
        .push1_dat (push1_dat),
        .pop       (RFLd),
        .head_dat  (head_dat),
        .entry_rd  (entry_rd),
        .entry_vld (entry_vld),
        .count     (count_w)
    );

    // Drain: the head is written every cycle the queue is non-empty, and the
    // register file captures it on the same edge that pops it.
    always_comb begin
        RFLd = count_w != '0;
        C    = RFLd ? head_dat.rd   : '0;
        PW   = RFLd ? head_dat.data : '0;
        PCLd = RFLd && (head_dat.rd == PC_REG);
    end

    // Includes the head being written now, so decode keeps stalling until
    // the write has actually landed.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i]) pending = pending | onehot16(entry_rd[i]);
        end
    end

    assign count = count_w;

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Purpose: self-checking bench for rf_writeback_queue (vector table + scoreboard).
// Latency: n/a.
// Backpressure: n/a.
module tb_rf_writeback_queue;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        mem_valid, alu_valid;
    logic [3:0]  mem_rd, alu_rd;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready;
    logic [3:0]  C;
    logic [31:0] PW;
    logic        RFLd, PCLd;
    logic [15:0] pending;
    logic [2:0]  count;

    rf_writeback_queue #(.DEPTH(DEPTH), .DW(32), .AW(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .C         (C),
        .PW        (PW),
        .RFLd      (RFLd),
        .PCLd      (PCLd),
        .pending   (pending),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        mv;
        logic [3:0]  mrd;
        logic [31:0] md;
        logic        av;
        logic [3:0]  ard;
        logic [31:0] ad;
        logic [31:0] ecnt;
        logic        erfld;
        logic [3:0]  ec;
        logic [31:0] epw;
        logic        epcld;
        logic [15:0] epend;
        logic        emr;
        logic        ear;
    } vec_t;

    localparam int NVEC = 20;
    vec_t        vecs [NVEC];
    exp_t        mq [$];
    logic [31:0] wlog [$];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          last_acc_m, last_acc_a;

    function automatic vec_t mk(int mv, int mrd, int md, int av, int ard, int ad,
                                int ecnt, int erfld, int ec, int epw, int epcld,
                                int epend, int emr, int ear);
        vec_t v;
        v.mv = 1'(mv);   v.mrd = 4'(mrd);  v.md = 32'(md);
        v.av = 1'(av);   v.ard = 4'(ard);  v.ad = 32'(ad);
        v.ecnt = 32'(ecnt); v.erfld = 1'(erfld); v.ec = 4'(ec); v.epw = 32'(epw);
        v.epcld = 1'(epcld); v.epend = 16'(epend); v.emr = 1'(emr); v.ear = 1'(ear);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mv, input logic [3:0] mrd, input logic [31:0] md,
                         input logic av, input logic [3:0] ard, input logic [31:0] ad);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
    endtask

    // Compare all outputs against the reference queue (called mid-cycle).
    task automatic model_check();
        int          sz;
        logic [15:0] ep;
        sz = mq.size();
        ep = '0;
        foreach (mq[i]) ep = ep | (16'h0001 << mq[i].rd);
        chk("count", 32'(count), 32'(sz));
        chk("count_le_depth", 32'(count <= 3'(DEPTH)), 32'd1);
        chk("rfld", 32'(RFLd), 32'(sz != 0));
        chk("pending", 32'(pending), 32'(ep));
        chk("mem_ready", 32'(mem_ready), 32'(sz < DEPTH));
        chk("alu_ready", 32'(alu_ready), 32'(mem_valid ? (sz + 2 <= DEPTH) : (sz < DEPTH)));
        if (sz != 0) begin
            chk("wr_C", 32'(C), 32'(mq[0].rd));
            chk("wr_PW", PW, mq[0].data);
            chk("wr_PCLd", 32'(PCLd), 32'(mq[0].rd == 4'd15));
            wlog.push_back(PW);
        end else begin
            chk("idle_PCLd", 32'(PCLd), 32'd0);
        end
    endtask

    // Advance the reference queue on the clock edge: pop head, then MEM, then ALU.
    task automatic model_update();
        int sz;
        bit am, aa;
        sz = mq.size();
        am = mem_valid && (sz < DEPTH);
        aa = alu_valid && (mem_valid ? (sz + 2 <= DEPTH) : (sz < DEPTH));
        if (sz != 0) void'(mq.pop_front());
        if (am) mq.push_back(exp_t'({mem_rd, mem_data}));
        if (aa) mq.push_back(exp_t'({alu_rd, alu_data}));
        last_acc_m = am;
        last_acc_a = aa;
    endtask

    task automatic tick();
        @(negedge CLK);
        model_check();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 50000");
        $fatal(1);
    end

    initial begin
        int r, km, ka;
        bit hit3;

        // Explicit table: inputs for one cycle and the outputs seen in that cycle.
        vecs[0]  = mk(1, 3, 90, 0, 0, 0,   0, 0, 0, 0, 0,   'h0000, 1, 1);
        vecs[1]  = mk(0, 0, 0,  0, 0, 0,   1, 1, 3, 90, 0,  'h0008, 1, 1);
        vecs[2]  = mk(0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0,   'h0000, 1, 1);
        vecs[3]  = mk(1, 1, 7,  1, 1, 16,  0, 0, 0, 0, 0,   'h0000, 1, 1);
        vecs[4]  = mk(0, 0, 0,  0, 0, 0,   2, 1, 1, 7, 0,   'h0002, 1, 1);
        vecs[5]  = mk(0, 0, 0,  0, 0, 0,   1, 1, 1, 16, 0,  'h0002, 1, 1);
        vecs[6]  = mk(0, 0, 0,  1, 15, 35, 0, 0, 0, 0, 0,   'h0000, 1, 1);
        vecs[7]  = mk(0, 0, 0,  1, 14, 44, 1, 1, 15, 35, 1, 'h8000, 1, 1);
        vecs[8]  = mk(0, 0, 0,  0, 0, 0,   1, 1, 14, 44, 0, 'h4000, 1, 1);
        vecs[9]  = mk(1, 2, 5,  1, 15, 99, 0, 0, 0, 0, 0,   'h0000, 1, 1);
        vecs[10] = mk(0, 0, 0,  0, 0, 0,   2, 1, 2, 5, 0,   'h8004, 1, 1);
        vecs[11] = mk(0, 0, 0,  0, 0, 0,   1, 1, 15, 99, 1, 'h8000, 1, 1);
        vecs[12] = mk(0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0,   'h0000, 1, 1);
        vecs[13] = mk(1, 4, 41, 1, 5, 51,  0, 0, 0, 0, 0,   'h0000, 1, 1);
        vecs[14] = mk(1, 6, 61, 1, 7, 71,  2, 1, 4, 41, 0,  'h0030, 1, 1);
        vecs[15] = mk(1, 8, 81, 1, 9, 91,  3, 1, 5, 51, 0,  'h00E0, 1, 0);
        vecs[16] = mk(0, 0, 0,  0, 0, 0,   3, 1, 6, 61, 0,  'h01C0, 1, 1);
        vecs[17] = mk(0, 0, 0,  0, 0, 0,   2, 1, 7, 71, 0,  'h0180, 1, 1);
        vecs[18] = mk(0, 0, 0,  0, 0, 0,   1, 1, 8, 81, 0,  'h0100, 1, 1);
        vecs[19] = mk(0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0,   'h0000, 1, 1);

        // Reset then idle.
        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_RFLd", 32'(RFLd), 32'd0);
        chk("rst_PCLd", 32'(PCLd), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        @(posedge CLK);
        #1;

        // Table-driven single write, dual push, PC write, near-full readies.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].mv, vecs[i].mrd, vecs[i].md, vecs[i].av, vecs[i].ard, vecs[i].ad);
            @(negedge CLK);
            model_check();
            chk($sformatf("vec%0d_count", i), 32'(count), vecs[i].ecnt);
            chk($sformatf("vec%0d_RFLd", i), 32'(RFLd), 32'(vecs[i].erfld));
            chk($sformatf("vec%0d_PCLd", i), 32'(PCLd), 32'(vecs[i].epcld));
            chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].epend));
            chk($sformatf("vec%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].emr));
            chk($sformatf("vec%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
            if (vecs[i].erfld) begin
                chk($sformatf("vec%0d_C", i), 32'(C), 32'(vecs[i].ec));
                chk($sformatf("vec%0d_PW", i), PW, vecs[i].epw);
            end
            @(posedge CLK);
            model_update();
            #1;
        end

        // ALU-only stream rd=2..9, data=rd*10, valid held until accepted.
        wlog.delete();
        r = 2;
        for (int cyc = 0; cyc < 30 && r <= 9; cyc++) begin
            drive(0, 0, 0, 1, 4'(r), 32'(r * 10));
            tick();
            if (last_acc_a) r++;
        end
        chk("alu_stream_done", 32'(r), 32'd10);
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        chk("alu_stream_len", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8 && i < wlog.size(); i++)
            chk($sformatf("alu_stream_%0d", i), wlog[i], 32'((i + 2) * 10));

        // Both sources held continuously: pointer wrap and count==3 backpressure.
        km = 0; ka = 0; hit3 = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            drive(1, 4'(km % 15), 32'(100 + km), 1, 4'((ka + 7) % 16), 32'(200 + ka));
            if (mq.size() == 3) hit3 = 1'b1;
            tick();
            if (last_acc_m) km++;
            if (last_acc_a) ka++;
        end
        chk("saw_count3_with_mem", 32'(hit3), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        repeat (5) tick();

        // Reset mid-operation with three entries queued.
        drive(1, 4'd10, 32'd1010, 1, 4'd11, 32'd1111);
        tick();
        drive(1, 4'd12, 32'd1212, 1, 4'd13, 32'd1313);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("pre_rst_count", 32'(count), 32'd3);
        #1 RST = 1'b1;
        #1;
        chk("mid_rst_RFLd", 32'(RFLd), 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        mq.delete();
        @(posedge CLK);
        @(negedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
